uart_debugger: RTL and testbench
================================

# uart_debugger

Debug telemetry bridge for the LED-matrix controller. It periodically snapshots a wide probe vector (`data_in`) and streams it as 8N1 UART bytes on `tx_out`. It also receives single-byte 8N1 commands on `debug_uart_rx_in` and presents each one with a one-cycle strobe. It sits beside the control path in the root clock domain; the top level decodes commands from it, for example `"H"` triggering a global reset.

## Interface
- `DIVIDER_TICKS`, default 727273: snapshot period in `clk_in` cycles.
- `DIVIDER_TICKS_WIDTH`, default 20: width of the snapshot period counter.
- `DATA_WIDTH`, default 192: probe width. Must be a multiple of 8.
- `DATA_WIDTH_BASE2`, default 8: width of the bit index into the snapshot. Must satisfy 2^DATA_WIDTH_BASE2 > DATA_WIDTH.
- `UART_TICKS_PER_BIT`, default 139: `clk_in` cycles per UART bit, shared by TX and RX.
- `UART_TICKS_PER_BIT_SIZE`, default 8: width of the baud counter.
- `clk_in` input 1: sole clock.
- `reset` input 1: asynchronous, active-low reset.
- `data_in` input DATA_WIDTH: probe vector, sampled only at snapshot instants.
- `debug_uart_rx_in` input 1: asynchronous command line, idles high.
- `debug_command` output 8: last valid received byte.
- `debug_command_pulse` output 1: one-cycle strobe when `debug_command` updates.
- `debug_command_busy` output 1: high while a received byte is in flight.
- `tx_out` output 1: telemetry serial line, idles high.

## Operation
- Reset values: `tx_out`=1, `debug_command`=8'h00, `debug_command_pulse`=0, `debug_command_busy`=0. Reset also clears all counters and returns both FSMs to IDLE. Asserting reset mid-frame aborts the frame immediately and drives `tx_out` high.
- Divider: free-running count 0..DIVIDER_TICKS-1. Each wrap produces a one-cycle `tick`.
- TX FSM states: IDLE, START, DATA, STOP.
  - On `tick` in IDLE: latch `data_in` into the snapshot register and begin a frame.
  - A `tick` that arrives while a frame is active is dropped, not queued.
- Frame content: DATA_WIDTH/8 bytes, most-significant byte (`data_in[DATA_WIDTH-1:DATA_WIDTH-8]`) first. There is no header and no gap between bytes.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly UART_TICKS_PER_BIT cycles.
- After the last byte's stop bit the FSM returns to IDLE.
- RX path:
  - `debug_uart_rx_in` passes through a 2-flop synchronizer.
  - A falling edge in IDLE enters START and raises `busy`.
  - At half a bit period the line is re-checked; if it is high, this is a glitch: return to IDLE and drop `busy`.
  - Each data bit is sampled every UART_TICKS_PER_BIT cycles after that (mid-bit), LSB first.
  - At the stop-bit sample: if the line is 1, load `debug_command` and pulse. If it is 0 (framing error), discard the byte with no pulse and leave `debug_command` unchanged.
  - `busy` falls in the same cycle the pulse rises, or at the discard.
- RX and TX are fully independent and may run simultaneously.

## Timing
- Snapshot capture happens on the `tick` cycle. `tx_out` goes low (start bit) on the next cycle.
- Frame length is (DATA_WIDTH/8)·10·UART_TICKS_PER_BIT cycles. With defaults: 24·10·139 = 33360 cycles, well inside DIVIDER_TICKS.
- `debug_command_pulse` is high for exactly 1 cycle. It rises 2 cycles (synchronizer) + 9.5 bit periods after the start-bit falling edge, ±1 cycle.
- `debug_command` is valid in the pulse cycle and holds until the next valid byte.

## Structure
- Sub-module `uart_tx`: a byte-wide 8N1 transmitter with `start`/`busy` handshake, instantiated once.
- RX, divider and frame sequencer stay in the top of this block.
- No shared package needed. The localparam BYTES = DATA_WIDTH/8 is local.

## Test plan
Bench parameters: DATA_WIDTH=16, DATA_WIDTH_BASE2=5, UART_TICKS_PER_BIT=4, DIVIDER_TICKS=200.
- Reset: hold `reset`=0 for 10 cycles. Required: `tx_out`=1, `debug_command`=0, `pulse`=0, `busy`=0 throughout.
- Telemetry frame: `data_in`=16'hA53C, wait for tick. Required: `tx_out` decodes as bytes 0xA5 then 0x3C, each bit 4 cycles wide, 80 cycles total, then idle high.
- Snapshot isolation: change `data_in` to 16'hFFFF one cycle after the tick. Required: the frame still carries 0xA5, 0x3C; the next frame carries 0xFF, 0xFF.
- Command receive: drive ASCII "H" (0x48) in 8N1 at 4 cycles/bit. Required: `busy` high during the byte, one pulse, `debug_command`=0x48.
- Framing error and glitch:
  - Send 0x55 with stop bit 0. Required: no pulse; `debug_command` keeps its prior value.
  - Drive a 1-cycle low glitch. Required: `busy` drops within 2 bit times, no pulse.
- Reset mid-frame: assert `reset` during byte 0. Required: `tx_out`=1 immediately. After release, the next tick starts a clean frame.

Source files
------------

// File: rtl/uart_tx.sv
// Byte-wide 8N1 transmitter. A start accepted in the last stop-bit cycle chains the next
// byte with no idle gap.
module uart_tx #(
    parameter int unsigned TICKS_PER_BIT = 139,
    parameter int unsigned TICKS_WIDTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    tx_state_e              state_q, state_d;
    logic [TICKS_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   bit_done;

    assign bit_done = (cnt_q == TICKS_WIDTH'(TICKS_PER_BIT - 1));
    assign busy     = (state_q != StIdle);
    assign tx       = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_done ? '0 : cnt_q + TICKS_WIDTH'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ready   = (state_q == StIdle) || ((state_q == StStop) && bit_done);
        unique case (state_q)
            StIdle: cnt_d = '0;
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (bit_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (start && ready) begin
            state_d = StStart;
            cnt_d   = '0;
            shift_d = data;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_debugger.sv
// Debug telemetry bridge: periodic probe snapshots streamed MSB byte first over UART TX,
// plus a single-byte 8N1 command receiver with a one-cycle strobe.
module uart_debugger #(
    parameter int unsigned DIVIDER_TICKS           = 727273,
    parameter int unsigned DIVIDER_TICKS_WIDTH     = 20,
    parameter int unsigned DATA_WIDTH              = 192,
    parameter int unsigned DATA_WIDTH_BASE2        = 8,
    parameter int unsigned UART_TICKS_PER_BIT      = 139,
    parameter int unsigned UART_TICKS_PER_BIT_SIZE = 8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  debug_uart_rx_in,
    output logic [7:0]            debug_command,
    output logic                  debug_command_pulse,
    output logic                  debug_command_busy,
    output logic                  tx_out
);

    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned HALF_BIT = UART_TICKS_PER_BIT / 2;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // Snapshot divider
    logic [DIVIDER_TICKS_WIDTH-1:0] div_q;
    logic                           tick;

    assign tick = (div_q == DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) div_q <= '0;
        else        div_q <= tick ? '0 : div_q + DIVIDER_TICKS_WIDTH'(1);
    end

    // Frame sequencer: snapshot is shifted left so the next byte is always at the top
    logic                        frame_active_q, frame_active_d;
    logic [DATA_WIDTH-1:0]       snapshot_q, snapshot_d;
    logic [DATA_WIDTH_BASE2-1:0] bits_left_q, bits_left_d;
    logic                        tx_start, tx_ready, tx_busy;
    logic [7:0]                  tx_data;

    always_comb begin
        frame_active_d = frame_active_q;
        snapshot_d     = snapshot_q;
        bits_left_d    = bits_left_q;
        tx_start       = 1'b0;
        tx_data        = snapshot_q[DATA_WIDTH-1 -: 8];
        if (!frame_active_q) begin
            if (tick) begin
                frame_active_d = 1'b1;
                snapshot_d     = data_in << 8;
                bits_left_d    = DATA_WIDTH_BASE2'((BYTES - 1) * 8);
                tx_start       = 1'b1;
                tx_data        = data_in[DATA_WIDTH-1 -: 8];
            end
        end else if (tx_ready && tx_busy) begin
            // Ready while busy marks the final stop-bit cycle of the current byte
            if (bits_left_q == '0) begin
                frame_active_d = 1'b0;
            end else begin
                tx_start    = 1'b1;
                snapshot_d  = snapshot_q << 8;
                bits_left_d = bits_left_q - DATA_WIDTH_BASE2'(8);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            frame_active_q <= 1'b0;
            snapshot_q     <= '0;
            bits_left_q    <= '0;
        end else begin
            frame_active_q <= frame_active_d;
            snapshot_q     <= snapshot_d;
            bits_left_q    <= bits_left_d;
        end
    end

    uart_tx #(
        .TICKS_PER_BIT (UART_TICKS_PER_BIT),
        .TICKS_WIDTH   (UART_TICKS_PER_BIT_SIZE)
    ) u_uart_tx (
        .clk   (clk_in),
        .rst_n (reset),
        .start (tx_start),
        .data  (tx_data),
        .ready (tx_ready),
        .busy  (tx_busy),
        .tx    (tx_out)
    );

    // Command receiver
    logic                               rx_sync1_q, rx_sync2_q, rx_prev_q;
    rx_state_e                          rx_state_q, rx_state_d;
    logic [UART_TICKS_PER_BIT_SIZE-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]                         rx_bit_q, rx_bit_d;
    logic [7:0]                         rx_shift_q, rx_shift_d;
    logic [7:0]                         cmd_q, cmd_d;
    logic                               pulse_q, pulse_d;
    logic                               rx_bit_end;

    assign rx_bit_end          = (rx_cnt_q == UART_TICKS_PER_BIT_SIZE'(UART_TICKS_PER_BIT - 1));
    assign debug_command       = cmd_q;
    assign debug_command_pulse = pulse_q;
    assign debug_command_busy  = (rx_state_q != RxIdle);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + UART_TICKS_PER_BIT_SIZE'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        cmd_d      = cmd_q;
        pulse_d    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = RxStart;
                    // The detect cycle counts toward the half-bit wait
                    rx_cnt_d   = UART_TICKS_PER_BIT_SIZE'(1);
                end
            end
            RxStart: begin
                if (rx_cnt_q >= UART_TICKS_PER_BIT_SIZE'(HALF_BIT - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync2_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RxStop: begin
                if (rx_bit_end) begin
                    rx_state_d = RxIdle;
                    if (rx_sync2_q) begin
                        cmd_d   = rx_shift_q;
                        pulse_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            cmd_q      <= '0;
            pulse_q    <= 1'b0;
        end else begin
            rx_sync1_q <= debug_uart_rx_in;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            cmd_q      <= cmd_d;
            pulse_q    <= pulse_d;
        end
    end

endmodule

// File: tb/tb_uart_debugger.sv
// Directed bench for uart_debugger: telemetry frames, snapshot isolation, mid-frame reset,
// command receive, framing error and glitch rejection.
module tb_uart_debugger;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        rx     = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic [7:0]  debug_command;
    logic        debug_command_pulse;
    logic        debug_command_busy;
    logic        tx_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    uart_debugger #(
        .DIVIDER_TICKS           (200),
        .DIVIDER_TICKS_WIDTH     (8),
        .DATA_WIDTH              (16),
        .DATA_WIDTH_BASE2        (5),
        .UART_TICKS_PER_BIT      (4),
        .UART_TICKS_PER_BIT_SIZE (3)
    ) dut (
        .clk_in              (clk_in),
        .reset               (reset),
        .data_in             (data_in),
        .debug_uart_rx_in    (rx),
        .debug_command       (debug_command),
        .debug_command_pulse (debug_command_pulse),
        .debug_command_busy  (debug_command_busy),
        .tx_out              (tx_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait for a start bit, update data_in right after the tick, then check all 80 cycles.
    task automatic frame_check(input string tag, input logic [15:0] exp,
                               input logic [15:0] next_data);
        int         wait_n;
        int         bad;
        int         pos;
        logic       exp_bit;
        logic [7:0] eb;
        logic [7:0] b0;
        logic [7:0] b1;
        wait_n = 0;
        while (tx_out !== 1'b0 && wait_n < 400) begin
            @(negedge clk_in);
            wait_n++;
        end
        if (tx_out !== 1'b0) begin
            check({tag, "_start"}, 32'(tx_out), 32'(0));
            return;
        end
        data_in = next_data;
        bad = 0;
        b0  = 8'h00;
        b1  = 8'h00;
        for (int i = 0; i < 80; i++) begin
            pos = (i % 40) / 4;
            eb  = (i < 40) ? exp[15:8] : exp[7:0];
            if (pos == 0)      exp_bit = 1'b0;
            else if (pos == 9) exp_bit = 1'b1;
            else               exp_bit = eb[pos-1];
            if (tx_out !== exp_bit) bad++;
            if ((i % 4) == 2 && pos >= 1 && pos <= 8) begin
                if (i < 40) b0[pos-1] = tx_out;
                else        b1[pos-1] = tx_out;
            end
            @(negedge clk_in);
        end
        check({tag, "_byte0"}, 32'(b0), 32'(exp[15:8]));
        check({tag, "_byte1"}, 32'(b1), 32'(exp[7:0]));
        check({tag, "_wave"}, 32'(bad), 32'(0));
        check({tag, "_idle"}, 32'(tx_out), 32'(1));
    endtask

    // Drive one 8N1 byte at 4 cycles/bit, then 12 idle cycles, counting pulse and busy cycles.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit,
                           output int pulses, output int busy_cycles);
        logic bit_v;
        pulses      = 0;
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      bit_v = 1'b0;
            else if (i == 9) bit_v = stop_bit;
            else             bit_v = b[i-1];
            for (int j = 0; j < 4; j++) begin
                rx = bit_v;
                @(negedge clk_in);
                pulses      += int'(debug_command_pulse);
                busy_cycles += int'(debug_command_busy);
            end
        end
        rx = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk_in);
            pulses      += int'(debug_command_pulse);
            busy_cycles += int'(debug_command_busy);
        end
    endtask

    initial begin
        int pulses;
        int busy_cycles;
        int wait_n;
        int busy_seen;

        // Reset hold
        data_in = 16'hA53C;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            check("rst_tx", 32'(tx_out), 32'(1));
            check("rst_cmd", 32'(debug_command), 32'(0));
            check("rst_pulse", 32'(debug_command_pulse), 32'(0));
            check("rst_busy", 32'(debug_command_busy), 32'(0));
        end
        reset = 1'b1;

        // Telemetry frames and snapshot isolation
        frame_check("frame_a53c", 16'hA53C, 16'hFFFF);
        frame_check("frame_ffff", 16'hFFFF, 16'h0000);

        // Reset during byte 0 of a frame carrying zeros
        wait_n = 0;
        while (tx_out !== 1'b0 && wait_n < 400) begin
            @(negedge clk_in);
            wait_n++;
        end
        check("mid_start", 32'(tx_out), 32'(0));
        repeat (10) @(negedge clk_in);
        check("mid_data_low", 32'(tx_out), 32'(0));
        reset = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx_out), 32'(1));
        data_in = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("mid_rst_hold", 32'(tx_out), 32'(1));
        end
        reset = 1'b1;
        frame_check("post_rst", 16'h1234, 16'h1234);

        // Command receive
        send_rx(8'h48, 1'b1, pulses, busy_cycles);
        check("h_pulses", 32'(pulses), 32'(1));
        check("h_cmd", 32'(debug_command), 32'(8'h48));
        check("h_busy_long", 32'(busy_cycles >= 30), 32'(1));
        check("h_busy_end", 32'(debug_command_busy), 32'(0));

        // Framing error
        send_rx(8'h55, 1'b0, pulses, busy_cycles);
        check("fe_pulses", 32'(pulses), 32'(0));
        check("fe_cmd", 32'(debug_command), 32'(8'h48));
        check("fe_busy_end", 32'(debug_command_busy), 32'(0));

        // One-cycle glitch
        pulses    = 0;
        busy_seen = 0;
        rx = 1'b0;
        @(negedge clk_in);
        rx = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk_in);
            pulses += int'(debug_command_pulse);
            if (debug_command_busy) busy_seen = 1;
        end
        check("gl_busy_seen", 32'(busy_seen), 32'(1));
        check("gl_busy_end", 32'(debug_command_busy), 32'(0));
        check("gl_pulses", 32'(pulses), 32'(0));
        check("gl_cmd", 32'(debug_command), 32'(8'h48));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
